// File: rtl/s_aes_pkg.sv
// Shared types, constants and GF(2^4) / S-AES helper functions for the
// multi-cycle S-AES engine.
package s_aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_KEYX = 3'd1,
    ST_RND0 = 3'd2,
    ST_RND1 = 3'd3,
    ST_RND2 = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  localparam logic       MODE_ENC = 1'b0;
  localparam logic       MODE_DEC = 1'b1;
  localparam logic [7:0] RCON1    = 8'h80;
  localparam logic [7:0] RCON2    = 8'h30;

  localparam logic [1:0] RSEL_0   = 2'd0;
  localparam logic [1:0] RSEL_1   = 2'd1;
  localparam logic [1:0] RSEL_2   = 2'd2;

  function automatic logic [3:0] sub_nib(input logic [3:0] n);
    case (n)
      4'h0: return 4'h9;  4'h1: return 4'h4;  4'h2: return 4'hA;  4'h3: return 4'hB;
      4'h4: return 4'hD;  4'h5: return 4'h1;  4'h6: return 4'h8;  4'h7: return 4'h5;
      4'h8: return 4'h6;  4'h9: return 4'h2;  4'hA: return 4'h0;  4'hB: return 4'h3;
      4'hC: return 4'hC;  4'hD: return 4'hE;  4'hE: return 4'hF;  4'hF: return 4'h7;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] inv_sub_nib(input logic [3:0] n);
    case (n)
      4'h0: return 4'hA;  4'h1: return 4'h5;  4'h2: return 4'h9;  4'h3: return 4'hB;
      4'h4: return 4'h1;  4'h5: return 4'h7;  4'h6: return 4'h8;  4'h7: return 4'hF;
      4'h8: return 4'h6;  4'h9: return 4'h0;  4'hA: return 4'h2;  4'hB: return 4'h3;
      4'hC: return 4'hC;  4'hD: return 4'h4;  4'hE: return 4'hD;  4'hF: return 4'hE;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [15:0] sub_word(input logic [15:0] s);
    return {sub_nib(s[15:12]), sub_nib(s[11:8]), sub_nib(s[7:4]), sub_nib(s[3:0])};
  endfunction

  function automatic logic [15:0] inv_sub_word(input logic [15:0] s);
    return {inv_sub_nib(s[15:12]), inv_sub_nib(s[11:8]), inv_sub_nib(s[7:4]), inv_sub_nib(s[3:0])};
  endfunction

  // Shift-and-add multiply, reducing by x^4+x+1 each time the operand overflows.
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] x;
    acc = 4'h0;
    x   = a;
    for (int i = 0; i < 4; i++) begin
      acc = acc ^ (b[i] ? x : 4'h0);
      x   = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  function automatic logic [15:0] shift_row(input logic [15:0] s);
    return {s[15:12], s[3:0], s[7:4], s[11:8]};
  endfunction

  function automatic logic [15:0] mix_col(input logic [15:0] s);
    return {s[15:12] ^ gf16_mul(4'h4, s[11:8]), gf16_mul(4'h4, s[15:12]) ^ s[11:8],
            s[7:4]   ^ gf16_mul(4'h4, s[3:0]),  gf16_mul(4'h4, s[7:4])   ^ s[3:0]};
  endfunction

  function automatic logic [15:0] inv_mix_col(input logic [15:0] s);
    return {gf16_mul(4'h9, s[15:12]) ^ gf16_mul(4'h2, s[11:8]),
            gf16_mul(4'h2, s[15:12]) ^ gf16_mul(4'h9, s[11:8]),
            gf16_mul(4'h9, s[7:4])   ^ gf16_mul(4'h2, s[3:0]),
            gf16_mul(4'h2, s[7:4])   ^ gf16_mul(4'h9, s[3:0])};
  endfunction

  // Returns {k1, k2}; k0 is the cipher key itself.
  function automatic logic [31:0] key_expand(input logic [15:0] key);
    logic [7:0] w0, w1, w2, w3, w4, w5;
    w0 = key[15:8];
    w1 = key[7:0];
    w2 = w0 ^ RCON1 ^ {sub_nib(w1[3:0]), sub_nib(w1[7:4])};
    w3 = w2 ^ w1;
    w4 = w2 ^ RCON2 ^ {sub_nib(w3[3:0]), sub_nib(w3[7:4])};
    w5 = w4 ^ w3;
    return {w2, w3, w4, w5};
  endfunction

endpackage

// File: rtl/s_aes_engine_ctrl_round.sv
// Combinational S-AES round unit shared by all three rounds; the caller
// selects the round and supplies the matching round key.
module s_aes_round_unit
  import s_aes_pkg::*;
(
  input  logic [15:0] i_state,
  input  logic [15:0] i_rkey,
  input  logic        i_mode,
  input  logic [1:0]  i_rsel,
  output logic [15:0] o_next
);

  // Round datapath selected by round index and direction.
  always_comb begin
    o_next = i_state;
    case (i_rsel)
      RSEL_0: o_next = i_state ^ i_rkey;
      RSEL_1: begin
        if (i_mode == MODE_ENC) begin
          o_next = mix_col(shift_row(sub_word(i_state))) ^ i_rkey;
        end else begin
          o_next = inv_mix_col(inv_sub_word(shift_row(i_state)) ^ i_rkey);
        end
      end
      RSEL_2: begin
        if (i_mode == MODE_ENC) begin
          o_next = shift_row(sub_word(i_state)) ^ i_rkey;
        end else begin
          o_next = inv_sub_word(shift_row(i_state)) ^ i_rkey;
        end
      end
      default: o_next = i_state;
    endcase
  end

endmodule

// File: rtl/s_aes_engine_ctrl.sv
// Multi-cycle S-AES engine: valid/ready request in, key expansion, three
// rounds on one shared round unit, result held until the consumer takes it.
module s_aes_engine_ctrl
  import s_aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic        i_in_mode,
  input  logic [15:0] i_in_key,
  input  logic [15:0] i_in_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [15:0] o_out_data,
  output logic        o_busy
);

  state_e      r_fsm;
  logic        r_mode;
  logic [15:0] r_key;
  logic [15:0] r_data;
  logic [15:0] r_k0;
  logic [15:0] r_k1;
  logic [15:0] r_k2;
  logic [15:0] r_s;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_busy;

  logic [1:0]  w_rsel;
  logic [15:0] w_round_in;
  logic [15:0] w_rkey;
  logic [15:0] w_round_out;
  logic [31:0] w_kx;

  assign w_kx = key_expand(r_key);

  // Round select and key routing; decrypt walks the key schedule backwards.
  always_comb begin
    w_rsel     = RSEL_0;
    w_round_in = r_s;
    w_rkey     = 16'h0000;
    case (r_fsm)
      ST_RND0: begin
        w_rsel     = RSEL_0;
        w_round_in = r_data;
        w_rkey     = (r_mode == MODE_ENC) ? r_k0 : r_k2;
      end
      ST_RND1: begin
        w_rsel = RSEL_1;
        w_rkey = r_k1;
      end
      ST_RND2: begin
        w_rsel = RSEL_2;
        w_rkey = (r_mode == MODE_ENC) ? r_k2 : r_k0;
      end
      default: begin
        w_rsel     = RSEL_0;
        w_round_in = r_s;
        w_rkey     = 16'h0000;
      end
    endcase
  end

  s_aes_round_unit u_round (
    .i_state (w_round_in),
    .i_rkey  (w_rkey),
    .i_mode  (r_mode),
    .i_rsel  (w_rsel),
    .o_next  (w_round_out)
  );

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= ST_IDLE;
      r_mode      <= MODE_ENC;
      r_key       <= 16'h0000;
      r_data      <= 16'h0000;
      r_k0        <= 16'h0000;
      r_k1        <= 16'h0000;
      r_k2        <= 16'h0000;
      r_s         <= 16'h0000;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (i_in_valid) begin
            r_mode     <= i_in_mode;
            r_key      <= i_in_key;
            r_data     <= i_in_data;
            r_fsm      <= ST_KEYX;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_KEYX: begin
          r_k0  <= r_key;
          r_k1  <= w_kx[31:16];
          r_k2  <= w_kx[15:0];
          r_fsm <= ST_RND0;
        end
        ST_RND0: begin
          r_s   <= w_round_out;
          r_fsm <= ST_RND1;
        end
        ST_RND1: begin
          r_s   <= w_round_out;
          r_fsm <= ST_RND2;
        end
        ST_RND2: begin
          r_s         <= w_round_out;
          r_fsm       <= ST_DONE;
          r_out_valid <= 1'b1;
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_fsm       <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_fsm       <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_s;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_s_aes_engine_ctrl.sv
// Self-checking bench for s_aes_engine_ctrl: a transaction-level S-AES model
// predicts handshakes and results every cycle; directed cases pin known vectors.
module tb_s_aes_engine_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_in_valid = 1'b0;
  logic        i_in_mode = 1'b0;
  logic [15:0] i_in_key = 16'h0000;
  logic [15:0] i_in_data = 16'h0000;
  logic        i_out_ready = 1'b0;
  logic        o_in_ready;
  logic        o_out_valid;
  logic [15:0] o_out_data;
  logic        o_busy;

  int n_cmp = 0;
  int n_bad = 0;

  s_aes_engine_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_mode   (i_in_mode),
    .i_in_key    (i_in_key),
    .i_in_data   (i_in_data),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference S-AES (table + textbook step order) ----------
  localparam logic [3:0] SB  [16] = '{4'h9,4'h4,4'hA,4'hB,4'hD,4'h1,4'h8,4'h5,
                                       4'h6,4'h2,4'h0,4'h3,4'hC,4'hE,4'hF,4'h7};
  localparam logic [3:0] ISB [16] = '{4'hA,4'h5,4'h9,4'hB,4'h1,4'h7,4'h8,4'hF,
                                       4'h6,4'h0,4'h2,4'h3,4'hC,4'h4,4'hD,4'hE};

  function automatic logic [3:0] gm(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = 7'd0;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (7'(a) << i);
    for (int i = 6; i >= 4; i--) if (p[i]) p = p ^ (7'b0010011 << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [15:0] nsub(input logic [15:0] s, input bit inv);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = inv ? ISB[s[4*i +: 4]] : SB[s[4*i +: 4]];
    return r;
  endfunction

  function automatic logic [15:0] swap13(input logic [15:0] s);
    return {s[15:12], s[3:0], s[7:4], s[11:8]};
  endfunction

  function automatic logic [15:0] mixc(input logic [15:0] s, input bit inv);
    logic [3:0] cd, co, a, b;
    logic [15:0] r;
    cd = inv ? 4'h9 : 4'h1;
    co = inv ? 4'h2 : 4'h4;
    r = 16'h0000;
    for (int c = 0; c < 2; c++) begin
      a = s[15-8*c -: 4];
      b = s[11-8*c -: 4];
      r[15-8*c -: 4] = gm(cd, a) ^ gm(co, b);
      r[11-8*c -: 4] = gm(co, a) ^ gm(cd, b);
    end
    return r;
  endfunction

  function automatic logic [7:0] gfun(input logic [7:0] w);
    return {SB[w[3:0]], SB[w[7:4]]};
  endfunction

  function automatic logic [15:0] rkey(input logic [15:0] key, input int idx);
    logic [7:0] w [6];
    w[0] = key[15:8];
    w[1] = key[7:0];
    w[2] = w[0] ^ 8'h80 ^ gfun(w[1]);
    w[3] = w[2] ^ w[1];
    w[4] = w[2] ^ 8'h30 ^ gfun(w[3]);
    w[5] = w[4] ^ w[3];
    return {w[2*idx], w[2*idx+1]};
  endfunction

  function automatic logic [15:0] ref_crypt(input logic mode, input logic [15:0] key, input logic [15:0] din);
    logic [15:0] s;
    if (!mode) begin
      s = din ^ rkey(key, 0);
      s = mixc(swap13(nsub(s, 1'b0)), 1'b0) ^ rkey(key, 1);
      s = swap13(nsub(s, 1'b0)) ^ rkey(key, 2);
    end else begin
      s = din ^ rkey(key, 2);
      s = nsub(swap13(s), 1'b1) ^ rkey(key, 1);
      s = mixc(s, 1'b1);
      s = nsub(swap13(s), 1'b1) ^ rkey(key, 0);
    end
    return s;
  endfunction

  // ---------------- transaction-level behavioural model --------------------
  logic        m_busy   = 1'b0;
  int          m_age    = 0;
  logic [15:0] m_result = 16'h0000;
  logic [15:0] m_last   = 16'h0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_age  = 0;
      m_last = 16'h0000;
    end else if (!m_busy) begin
      if (i_in_valid) begin
        m_busy   = 1'b1;
        m_age    = 0;
        m_result = ref_crypt(i_in_mode, i_in_key, i_in_data);
      end
    end else if (m_age >= 4) begin
      if (i_out_ready) begin
        m_busy = 1'b0;
        m_last = m_result;
      end
    end else begin
      m_age = m_age + 1;
    end
  end

  always @(negedge clk) begin
    chk("in_ready",  {15'd0, o_in_ready},  {15'd0, !m_busy});
    chk("busy",      {15'd0, o_busy},      {15'd0, m_busy});
    chk("out_valid", {15'd0, o_out_valid}, {15'd0, (m_busy && m_age >= 4)});
    if (m_busy && m_age >= 4) chk("out_data", o_out_data, m_result);
    else if (!m_busy || m_age < 2) chk("out_data_hold", o_out_data, m_last);
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_one(input logic mode, input logic [15:0] key, input logic [15:0] data,
                         input logic [15:0] exp, input string nm);
    int lat;
    i_in_valid = 1'b1;
    i_in_mode  = mode;
    i_in_key   = key;
    i_in_data  = data;
    tick();
    i_in_valid = 1'b0;
    lat = 0;
    while (!o_out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({nm, "_latency"}, 16'(lat), 16'd4);
    chk({nm, "_data"}, o_out_data, exp);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_in_ready",  {15'd0, o_in_ready},  16'd1);
    chk("rst_out_valid", {15'd0, o_out_valid}, 16'd0);
    chk("rst_busy",      {15'd0, o_busy},      16'd0);
    chk("rst_out_data",  o_out_data,           16'h0000);
    rst_n = 1'b1;

    chk("model_k1",  rkey(16'hA73B, 1), 16'h1C27);
    chk("model_k2",  rkey(16'hA73B, 2), 16'h7651);
    chk("model_enc", ref_crypt(1'b0, 16'hA73B, 16'h6F6B), 16'h0738);
    chk("model_dec", ref_crypt(1'b1, 16'hA73B, 16'h0738), 16'h6F6B);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] k, d;
      k = 16'($urandom);
      d = 16'($urandom);
      chk("model_roundtrip", ref_crypt(1'b1, k, ref_crypt(1'b0, k, d)), d);
    end

    tick();
    i_out_ready = 1'b1;
    run_one(1'b0, 16'hA73B, 16'h6F6B, 16'h0738, "enc");
    tick();
    run_one(1'b1, 16'hA73B, 16'h0738, 16'h6F6B, "dec");
    tick();

    // Backpressure: result must hold for ten cycles without out_ready.
    i_out_ready = 1'b0;
    run_one(1'b0, 16'hA73B, 16'h6F6B, 16'h0738, "bp");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid",    {15'd0, o_out_valid}, 16'd1);
      chk("bp_data",     o_out_data,           16'h0738);
      chk("bp_in_ready", {15'd0, o_in_ready},  16'd0);
    end
    i_out_ready = 1'b1;
    tick();
    chk("bp_release_ready", {15'd0, o_in_ready},  16'd1);
    chk("bp_release_valid", {15'd0, o_out_valid}, 16'd0);

    // Request arriving in RND1 must be ignored.
    begin
      int lat;
      i_in_valid = 1'b1; i_in_mode = 1'b0; i_in_key = 16'hA73B; i_in_data = 16'h6F6B;
      tick();
      i_in_valid = 1'b0;
      tick();
      tick();
      i_in_valid = 1'b1; i_in_mode = 1'b1; i_in_data = 16'hFFFF;
      tick();
      i_in_valid = 1'b0;
      lat = 3;
      while (!o_out_valid && lat < 20) begin
        tick();
        lat++;
      end
      chk("busyreq_latency", 16'(lat), 16'd4);
      chk("busyreq_data", o_out_data, 16'h0738);
      tick();
    end

    // Reset in RND1 drops the request.
    i_in_valid = 1'b1; i_in_mode = 1'b0; i_in_key = 16'hA73B; i_in_data = 16'h6F6B;
    tick();
    i_in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  {15'd0, o_in_ready},  16'd1);
    chk("midrst_out_valid", {15'd0, o_out_valid}, 16'd0);
    chk("midrst_busy",      {15'd0, o_busy},      16'd0);
    chk("midrst_out_data",  o_out_data,           16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    run_one(1'b0, 16'hA73B, 16'h6F6B, 16'h0738, "after_rst");
    tick();

    // Back-to-back alternating encrypt/decrypt with in_valid held high.
    i_in_mode  = 1'b0;
    i_in_key   = 16'($urandom);
    i_in_data  = 16'($urandom);
    i_in_valid = 1'b1;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (o_in_ready) begin
        i_in_mode = ~i_in_mode;
        i_in_key  = 16'($urandom);
        i_in_data = 16'($urandom);
      end
    end
    i_in_valid = 1'b0;
    for (int c = 0; c < 8; c++) tick();

    // Random traffic with sporadic resets.
    for (int c = 0; c < 3000; c++) begin
      i_in_valid  = 1'($urandom_range(0, 1));
      i_out_ready = ($urandom_range(0, 3) != 0);
      i_in_mode   = 1'($urandom_range(0, 1));
      i_in_key    = 16'($urandom);
      i_in_data   = 16'($urandom);
      rst_n       = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    i_in_valid = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
